// File: rtl/coin_collector.sv
`default_nettype none
// ============================================================================
// Module   : coin_collector
// Purpose  : Sequential payment front end for the vending datapath. Latches a
//            cost, accepts one coin per cycle and accumulates the amount paid
//            in nickel units (1 = nickel, 2 = dime, 5 = quarter, max 15).
//            Once enough has been paid, the transaction is presented through
//            a vend_valid/vend_ack handshake. On acknowledge, the
//            transaction's coins are banked into a cash box that saturates
//            at 3 per denomination. A cancel returns the coins greedily,
//            largest first, through a refund_valid/refund_ack handshake.
// Ports    : clock, reset          - clock, asynchronous active-high reset
//            start, cost[3:0]      - begin a transaction (IDLE only, cost != 0)
//            coin_valid,
//            coin_type[2:0]        - coin presented this cycle
//            cancel                - abort and refund (COLLECT only)
//            vend_ack, refund_ack  - downstream handshake acknowledges
//            coin_accept/reject    - one-cycle verdict on the presented coin
//            paid[3:0]             - running total of the transaction
//            vend_valid            - payment complete, waiting for vend_ack
//            refund_valid,
//            refund_coin[2:0]      - coin to eject (0 when not refunding)
//            busy                  - any state other than IDLE
//            quarters/dimes/nickels[1:0] - saturating cash-box inventory
// Revision : 1.0 - initial release
// ============================================================================
module coin_collector (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] cost,
    input  logic       coin_valid,
    input  logic [2:0] coin_type,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       refund_ack,
    output logic       coin_accept,
    output logic       coin_reject,
    output logic [3:0] paid,
    output logic       vend_valid,
    output logic       refund_valid,
    output logic [2:0] refund_coin,
    output logic       busy,
    output logic [1:0] quarters,
    output logic [1:0] dimes,
    output logic [1:0] nickels
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_VEND    = 2'd2;
    localparam logic [1:0] S_REFUND  = 2'd3;

    localparam logic [2:0] C_NICKEL   = 3'd1;
    localparam logic [2:0] C_DIME     = 3'd2;
    localparam logic [2:0] C_QUARTER  = 3'd5;
    localparam logic [4:0] C_MAX_PAID = 5'd15;
    localparam logic [1:0] C_INV_MAX  = 2'd3;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [3:0] r_cost;
    logic [3:0] r_paid;
    logic [3:0] r_tq;
    logic [3:0] r_td;
    logic [3:0] r_tn;
    logic [1:0] r_inv_q;
    logic [1:0] r_inv_d;
    logic [1:0] r_inv_n;
    logic       r_coin_accept;
    logic       r_coin_reject;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [1:0] w_state;
    logic [3:0] w_cost;
    logic [3:0] w_paid;
    logic [3:0] w_tq;
    logic [3:0] w_td;
    logic [3:0] w_tn;
    logic [1:0] w_inv_q;
    logic [1:0] w_inv_d;
    logic [1:0] w_inv_n;
    logic       w_coin_accept;
    logic       w_coin_reject;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic       w_coin_legal;
    logic [4:0] w_paid_sum;
    logic       w_coin_fits;
    logic [2:0] w_refund_val;

    assign w_coin_legal = (coin_type == C_NICKEL) || (coin_type == C_DIME) ||
                          (coin_type == C_QUARTER);

    // 5-bit sum so an over-limit coin is detected instead of wrapping.
    assign w_paid_sum  = {1'b0, r_paid} + {2'b00, coin_type};
    assign w_coin_fits = w_coin_legal && (w_paid_sum <= C_MAX_PAID);

    // Greedy refund: largest denomination still held goes out first.
    assign w_refund_val = (r_tq != 4'd0) ? C_QUARTER :
                          (r_td != 4'd0) ? C_DIME    : C_NICKEL;

    function automatic logic [1:0] sat_add(input logic [1:0] inv,
                                           input logic [3:0] cnt);
        logic [4:0] sum;
        sum = {3'b000, inv} + {1'b0, cnt};
        return (sum > {3'b000, C_INV_MAX}) ? C_INV_MAX : sum[1:0];
    endfunction

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state       = r_state;
        w_cost        = r_cost;
        w_paid        = r_paid;
        w_tq          = r_tq;
        w_td          = r_td;
        w_tn          = r_tn;
        w_inv_q       = r_inv_q;
        w_inv_d       = r_inv_d;
        w_inv_n       = r_inv_n;
        w_coin_accept = 1'b0;
        w_coin_reject = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_coin_reject = coin_valid;
                if (start && (cost != 4'd0)) begin
                    w_cost  = cost;
                    w_paid  = 4'd0;
                    w_tq    = 4'd0;
                    w_td    = 4'd0;
                    w_tn    = 4'd0;
                    w_state = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel) begin
                    // Cancel has priority; a simultaneous coin goes back.
                    w_coin_reject = coin_valid;
                    w_state       = (r_paid == 4'd0) ? S_IDLE : S_REFUND;
                end else if (coin_valid) begin
                    if (w_coin_fits) begin
                        w_coin_accept = 1'b1;
                        w_paid        = w_paid_sum[3:0];
                        if (coin_type == C_QUARTER) begin
                            w_tq = r_tq + 4'd1;
                        end else if (coin_type == C_DIME) begin
                            w_td = r_td + 4'd1;
                        end else begin
                            w_tn = r_tn + 4'd1;
                        end
                        if (w_paid_sum >= {1'b0, r_cost}) begin
                            w_state = S_VEND;
                        end
                    end else begin
                        w_coin_reject = 1'b1;
                    end
                end
            end

            S_VEND: begin
                w_coin_reject = coin_valid;
                if (vend_ack) begin
                    w_inv_q = sat_add(r_inv_q, r_tq);
                    w_inv_d = sat_add(r_inv_d, r_td);
                    w_inv_n = sat_add(r_inv_n, r_tn);
                    w_paid  = 4'd0;
                    w_tq    = 4'd0;
                    w_td    = 4'd0;
                    w_tn    = 4'd0;
                    w_state = S_IDLE;
                end
            end

            S_REFUND: begin
                w_coin_reject = coin_valid;
                if (refund_ack) begin
                    w_paid = r_paid - {1'b0, w_refund_val};
                    if (r_tq != 4'd0) begin
                        w_tq = r_tq - 4'd1;
                    end else if (r_td != 4'd0) begin
                        w_td = r_td - 4'd1;
                    end else begin
                        w_tn = r_tn - 4'd1;
                    end
                    // The coin being acked is the last one when it equals
                    // the whole remaining balance.
                    if (r_paid == {1'b0, w_refund_val}) begin
                        w_state = S_IDLE;
                    end
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cost        <= 4'd0;
            r_paid        <= 4'd0;
            r_tq          <= 4'd0;
            r_td          <= 4'd0;
            r_tn          <= 4'd0;
            r_inv_q       <= 2'd0;
            r_inv_d       <= 2'd0;
            r_inv_n       <= 2'd0;
            r_coin_accept <= 1'b0;
            r_coin_reject <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cost        <= w_cost;
            r_paid        <= w_paid;
            r_tq          <= w_tq;
            r_td          <= w_td;
            r_tn          <= w_tn;
            r_inv_q       <= w_inv_q;
            r_inv_d       <= w_inv_d;
            r_inv_n       <= w_inv_n;
            r_coin_accept <= w_coin_accept;
            r_coin_reject <= w_coin_reject;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: registered or decoded from registered state only
    // ------------------------------------------------------------------
    assign coin_accept  = r_coin_accept;
    assign coin_reject  = r_coin_reject;
    assign paid         = r_paid;
    assign vend_valid   = (r_state == S_VEND);
    assign refund_valid = (r_state == S_REFUND);
    assign refund_coin  = (r_state == S_REFUND) ? w_refund_val : 3'd0;
    assign busy         = (r_state != S_IDLE);
    assign quarters     = r_inv_q;
    assign dimes        = r_inv_d;
    assign nickels      = r_inv_n;

endmodule
`default_nettype wire

// File: tb/tb_coin_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_collector
// Purpose  : Scoreboard bench for coin_collector. A transaction-level model
//            (a list of held coins plus an inventory array) predicts every
//            cycle's outputs. Monitors compare DUT outputs against the
//            queued predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_collector;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] cost;
    logic       coin_valid;
    logic [2:0] coin_type;
    logic       cancel;
    logic       vend_ack;
    logic       refund_ack;
    logic       coin_accept;
    logic       coin_reject;
    logic [3:0] paid;
    logic       vend_valid;
    logic       refund_valid;
    logic [2:0] refund_coin;
    logic       busy;
    logic [1:0] quarters;
    logic [1:0] dimes;
    logic [1:0] nickels;

    coin_collector dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .cost        (cost),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .cancel      (cancel),
        .vend_ack    (vend_ack),
        .refund_ack  (refund_ack),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .paid        (paid),
        .vend_valid  (vend_valid),
        .refund_valid(refund_valid),
        .refund_coin (refund_coin),
        .busy        (busy),
        .quarters    (quarters),
        .dimes       (dimes),
        .nickels     (nickels)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues
    logic [17:0] snap_q[$];  // full per-cycle output picture
    logic [5:0]  coin_q[$];  // {accept, vend_valid, paid} per presented coin

    // Transaction-level reference model
    int m_mode;          // 0 idle, 1 collecting, 2 vending, 3 refunding
    int m_cost;
    int m_coins[$];      // coins held for the current transaction
    int m_inv[3];        // quarters, dimes, nickels in the cash box

    function automatic int m_paid();
        int s = 0;
        foreach (m_coins[i]) s += m_coins[i];
        return s;
    endfunction

    function automatic int m_max_coin();
        int m = 0;
        foreach (m_coins[i]) if (m_coins[i] > m) m = m_coins[i];
        return m;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cost = 0;
        m_coins.delete();
        m_inv[0] = 0; m_inv[1] = 0; m_inv[2] = 0;
        snap_q.delete();
        coin_q.delete();
    endtask

    task automatic model_step(input bit st, input int cst, input bit cv, input int ct,
                              input bit cn, input bit va, input bit ra);
        bit acc = 0;
        bit rej = 0;
        int cnt[3];
        int v;
        int p;
        case (m_mode)
            0: begin
                if (cv) rej = 1;
                if (st && cst != 0) begin
                    m_cost = cst;
                    m_coins.delete();
                    m_mode = 1;
                end
            end
            1: begin
                if (cn) begin
                    if (cv) rej = 1;
                    m_mode = (m_paid() == 0) ? 0 : 3;
                end else if (cv) begin
                    if ((ct == 1 || ct == 2 || ct == 5) && (m_paid() + ct <= 15)) begin
                        m_coins.push_back(ct);
                        acc = 1;
                        if (m_paid() >= m_cost) m_mode = 2;
                    end else begin
                        rej = 1;
                    end
                end
            end
            2: begin
                if (cv) rej = 1;
                if (va) begin
                    cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
                    foreach (m_coins[i]) begin
                        if (m_coins[i] == 5) cnt[0]++;
                        else if (m_coins[i] == 2) cnt[1]++;
                        else cnt[2]++;
                    end
                    for (int k = 0; k < 3; k++)
                        m_inv[k] = (m_inv[k] + cnt[k] > 3) ? 3 : m_inv[k] + cnt[k];
                    m_coins.delete();
                    m_mode = 0;
                end
            end
            default: begin
                if (cv) rej = 1;
                if (ra) begin
                    v = m_max_coin();
                    for (int i = 0; i < m_coins.size(); i++) begin
                        if (m_coins[i] == v) begin
                            m_coins.delete(i);
                            break;
                        end
                    end
                    if (m_coins.size() == 0) m_mode = 0;
                end
            end
        endcase
        p = m_paid();
        if (cv) coin_q.push_back({acc, (m_mode == 2), 4'(p)});
        snap_q.push_back({(m_mode != 0), (m_mode == 2), (m_mode == 3),
                          3'((m_mode == 3) ? m_max_coin() : 0), 4'(p),
                          2'(m_inv[0]), 2'(m_inv[1]), 2'(m_inv[2]), acc, rej});
    endtask

    task automatic step(input bit st, input int cst, input bit cv, input int ct,
                        input bit cn, input bit va, input bit ra);
        @(negedge clock);
        start      = st;
        cost       = 4'(cst);
        coin_valid = cv;
        coin_type  = 3'(ct);
        cancel     = cn;
        vend_ack   = va;
        refund_ack = ra;
        model_step(st, cst, cv, ct, cn, va, ra);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic begin_txn(input int c);
        step(1, c, 0, 0, 0, 0, 0);
    endtask

    task automatic coin(input int v);
        step(0, 0, 1, v, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        logic [20:0] act;
        act = {coin_accept, coin_reject, paid, vend_valid, refund_valid,
               refund_coin, busy, quarters, dimes, nickels};
        checks++;
        if (act !== 21'd0) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=0", tag, $time, act);
        end
    endtask

    // Monitor: per-cycle picture and coin-verdict events
    initial begin
        logic [17:0] exp_s;
        logic [17:0] act_s;
        logic [5:0]  exp_c;
        logic [5:0]  act_c;
        forever begin
            @(posedge clock);
            #1;
            if (snap_q.size() > 0) begin
                exp_s = snap_q.pop_front();
                act_s = {busy, vend_valid, refund_valid, refund_coin, paid,
                         quarters, dimes, nickels, coin_accept, coin_reject};
                checks++;
                if (act_s !== exp_s) begin
                    errors++;
                    $display("FAIL snapshot t=%0t actual=%h required=%h", $time, act_s, exp_s);
                end
            end
            if (coin_accept || coin_reject) begin
                checks++;
                act_c = {coin_accept, vend_valid, paid};
                if (coin_q.size() == 0) begin
                    errors++;
                    $display("FAIL coin_event t=%0t actual=%h required=none", $time, act_c);
                end else begin
                    exp_c = coin_q.pop_front();
                    if (act_c !== exp_c) begin
                        errors++;
                        $display("FAIL coin_event t=%0t actual=%h required=%h", $time, act_c, exp_c);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        bit st, cv, cn, va, ra;
        int cst, ct, r;

        reset = 1'b1;
        start = 0; cost = 0; coin_valid = 0; coin_type = 0;
        cancel = 0; vend_ack = 0; refund_ack = 0;
        model_reset();
        #12;
        check_reset_outputs("reset_initial");
        @(negedge clock);
        reset = 1'b0;

        // Basic purchase: cost 8 paid with 5, 2, 1
        begin_txn(8);
        coin(5); coin(2); coin(1);
        idle();
        step(0, 0, 0, 0, 0, 1, 0);
        idle();

        // Asynchronous reset mid-collect with paid = 7
        begin_txn(9);
        coin(5); coin(2);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("reset_async");
        model_reset();
        #1;
        reset = 1'b0;
        idle();

        // Overflow and invalid coins, cost 15, then refund all
        begin_txn(15);
        coin(5); coin(5); coin(2);
        coin(5);
        coin(3);
        coin(2);
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 1);
        idle();

        // Cancel after 5, 2 with a stalled ack in between
        begin_txn(10);
        coin(5); coin(2);
        step(0, 0, 0, 0, 1, 0, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        idle();

        // Quarter saturation over two transactions
        for (int t = 0; t < 2; t++) begin
            begin_txn(10);
            coin(5); coin(5);
            step(0, 0, 0, 0, 0, 1, 0);
        end
        idle();

        // Cancel together with a coin while paid = 1
        begin_txn(5);
        coin(1);
        step(0, 0, 1, 5, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        idle();

        // Coin offered during VEND, start with cost 0, coin in IDLE
        begin_txn(2);
        coin(2);
        coin(5);
        step(0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        coin(1);
        idle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st  = ($urandom_range(0, 3) == 0);
            cst = $urandom_range(0, 15);
            cv  = $urandom_range(0, 1) == 1;
            r   = $urandom_range(0, 9);
            if (r < 3)      ct = 5;
            else if (r < 5) ct = 2;
            else if (r < 7) ct = 1;
            else            ct = $urandom_range(0, 7);
            cn  = ($urandom_range(0, 19) == 0);
            va  = ($urandom_range(0, 2) == 0);
            ra  = $urandom_range(0, 1) == 1;
            step(st, cst, cv, ct, cn, va, ra);
        end
        idle();
        idle();
        @(posedge clock);
        #2;

        checks++;
        if (snap_q.size() != 0 || coin_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain actual=%0d/%0d required=0/0", snap_q.size(), coin_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
